// File: rtl/rtmc_spi_bridge.sv
// rtmc_spi_bridge: SPI mode-0 slave that turns each 32-bit host frame into one
// register-bus read or write, returning read data on MISO within the same frame.
module rtmc_spi_bridge #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdat,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdat,
    input  logic              reg_ack,
    output logic              busy,
    output logic              bus_timeout
);

    typedef enum logic [2:0] {IDLE, SHIFT, RD_REQ, WR_REQ, WAIT_CS} state_e;

    localparam logic [7:0]  TO_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [15:0] RD_FAIL = 16'hDEAD;

    logic              sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic              cs_meta_q, cs_sync_q, cs_prev_q;
    logic              mosi_meta_q, mosi_sync_q;
    state_e            state_q, state_d;
    logic [5:0]        bit_cnt_q;
    logic [22:0]       rx_q;
    logic              cmd_q;
    logic [15:0]       tx_q;
    logic              miso_q;
    logic [7:0]        to_cnt_q;
    logic              bus_timeout_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdat_q;

    logic sclk_rise, sclk_fall, cs_fall;
    logic rd_trig, wr_trig, req_active, to_hit, data_phase;

    // NOTE: non-blocking <= makes every flop sample its pre-edge input; with =
    // the three synchronizer stages below would collapse into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= spi_sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= spi_cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sclk_rise  = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall  = ~sclk_sync_q & sclk_prev_q;
    assign cs_fall    = ~cs_sync_q & cs_prev_q;
    assign data_phase = (bit_cnt_q[5:4] == 2'b01);
    assign rd_trig    = sclk_rise && (bit_cnt_q == 6'd15) && !cmd_q;
    assign wr_trig    = sclk_rise && (bit_cnt_q == 6'd31) && cmd_q;
    assign req_active = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign to_hit     = (to_cnt_q == TO_LAST) && !reg_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            cmd_q     <= 1'b0;
        end else if (cs_fall) begin
            bit_cnt_q <= '0;
        end else if (sclk_rise && !cs_sync_q) begin
            if (bit_cnt_q != 6'd32) bit_cnt_q <= bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd0) cmd_q <= mosi_sync_q;
            rx_q <= {rx_q[21:0], mosi_sync_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case, so no path through this
    // block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT: begin
                if (cs_sync_q)    state_d = IDLE;
                else if (rd_trig) state_d = RD_REQ;
                else if (wr_trig) state_d = WR_REQ;
            end
            RD_REQ, WR_REQ: begin
                if (reg_ack || to_hit) state_d = cs_sync_q ? IDLE : WAIT_CS;
            end
            WAIT_CS: if (cs_sync_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reg_rd = (state_q == RD_REQ);
        reg_wr = (state_q == WR_REQ);
        busy   = (state_q != IDLE);
    end

    // Address/data are captured from the live MOSI bit so the strobe can rise
    // one clk after the triggering SCLK edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            wdat_q        <= '0;
            to_cnt_q      <= '0;
            tx_q          <= '0;
            miso_q        <= 1'b0;
            bus_timeout_q <= 1'b0;
        end else begin
            if (state_q == SHIFT && state_d == RD_REQ) begin
                addr_q <= {rx_q[6:0], mosi_sync_q};
            end
            if (state_q == SHIFT && state_d == WR_REQ) begin
                addr_q <= rx_q[22:15];
                wdat_q <= {rx_q[14:0], mosi_sync_q};
            end

            to_cnt_q      <= req_active ? to_cnt_q + 8'd1 : 8'd0;
            bus_timeout_q <= req_active && to_hit;

            if (state_q == RD_REQ && reg_ack) begin
                tx_q <= reg_rdat;
            end else if (state_q == RD_REQ && to_hit) begin
                tx_q <= RD_FAIL;
            end else if (state_q == WAIT_CS && sclk_fall && data_phase) begin
                tx_q <= {tx_q[14:0], 1'b0};
            end

            if (cs_sync_q) begin
                miso_q <= 1'b0;
            end else if (sclk_fall) begin
                miso_q <= (state_q == WAIT_CS && data_phase) ? tx_q[15] : 1'b0;
            end
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = ~cs_sync_q;
    assign reg_addr    = addr_q;
    assign reg_wdat    = wdat_q;
    assign bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_rtmc_spi_bridge.sv
// Bench for rtmc_spi_bridge: a table of frames, hand-written abort/reset
// sequences, and random frames checked against a transaction-level model.
module tb_rtmc_spi_bridge;

    localparam int ACK_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdat;
    logic        reg_wr, reg_rd;
    logic [15:0] reg_rdat = '0;
    logic        reg_ack = 1'b0;
    logic        busy, bus_timeout;

    rtmc_spi_bridge #(.ADDR_W(8), .DATA_W(16), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .reg_addr(reg_addr), .reg_wdat(reg_wdat), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdat(reg_rdat), .reg_ack(reg_ack),
        .busy(busy), .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] wdat;
        int          len;
    } txn_t;

    typedef struct {
        logic [31:0] frame;
        int          nbits;
        int          ack_delay;
        int          hold16;
        int          exp_txn;
        bit          exp_wr;
        logic [7:0]  exp_addr;
        logic [15:0] exp_wdat;
        int          exp_len;
        logic [15:0] exp_rdata;
        int          exp_to;
    } vec_t;

    txn_t        txq[$];
    int          hi_cnt = 0, ack_delay = 1, to_pulses = 0, overlap = 0;
    bit          cur_wr;
    logic [7:0]  cur_addr;
    logic [15:0] cur_wdat;
    logic [15:0] slave_mem [256];
    logic [15:0] model_mem [256];
    int          n_vec = 0, n_err = 0;

    function automatic logic [15:0] mem_init(int i);
        logic [7:0] a;
        a = 8'(i);
        return (a == 8'h00) ? 16'h0142 : {a, ~a};
    endfunction

    // Register-bus slave: acks on the ack_delay-th strobe cycle (0 = never)
    // and logs each strobe as one transaction with its high time.
    always @(negedge clk) begin
        if (reg_rd && reg_wr) overlap++;
        if (bus_timeout) to_pulses++;
        if (reg_rd || reg_wr) begin
            if (hi_cnt == 0) begin
                cur_wr = reg_wr;
                cur_addr = reg_addr;
                cur_wdat = reg_wdat;
            end
            hi_cnt++;
            if (hi_cnt == ack_delay) begin
                reg_ack = 1'b1;
                if (reg_wr) slave_mem[reg_addr] = reg_wdat;
                else        reg_rdat = slave_mem[reg_addr];
            end else begin
                reg_ack = 1'b0;
                reg_rdat = 16'($urandom);
            end
        end else begin
            if (hi_cnt != 0) begin
                txq.push_back('{cur_wr, cur_addr, cur_wdat, hi_cnt});
                hi_cnt = 0;
            end
            reg_ack = 1'b0;
            reg_rdat = 16'($urandom);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "/strobes"}, 32'({reg_rd, reg_wr, busy, bus_timeout}), 32'd0);
        check({tag, "/miso"}, 32'({spi_miso, spi_miso_oe}), 32'd0);
        check({tag, "/addr"}, 32'(reg_addr), 32'd0);
        check({tag, "/wdat"}, 32'(reg_wdat), 32'd0);
    endtask

    task automatic spi_bit(input logic b, input int hold, output logic mi);
        spi_mosi = b;
        repeat (4) @(negedge clk);
        mi = spi_miso;
        spi_sclk = 1'b1;
        repeat (4 + hold) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [31:0] f, input int nbits, input int hold16,
                             output logic [31:0] miso_w, output logic tail);
        logic mi;
        miso_w = '0;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(f[31-i], (i == 15) ? hold16 : 0, mi);
            miso_w[31-i] = mi;
        end
        repeat (4) @(negedge clk);
        tail = spi_miso;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || reg_rd || reg_wr) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/busy"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] mw;
        logic        tail;
        txn_t        t;
        txq.delete();
        to_pulses = 0;
        ack_delay = v.ack_delay;
        spi_frame(v.frame, v.nbits, v.hold16, mw, tail);
        wait_idle(tag);
        check({tag, "/ntxn"}, 32'(txq.size()), 32'(v.exp_txn));
        check({tag, "/tmo"}, 32'(to_pulses), 32'(v.exp_to));
        check({tag, "/ovl"}, 32'(overlap), 32'd0);
        if (v.exp_txn != 0 && txq.size() != 0) begin
            t = txq[0];
            check({tag, "/wr"}, 32'(t.wr), 32'(v.exp_wr));
            check({tag, "/addr"}, 32'(t.addr), 32'(v.exp_addr));
            check({tag, "/len"}, 32'(t.len), 32'(v.exp_len));
            if (v.exp_wr) check({tag, "/wdat"}, 32'(t.wdat), 32'(v.exp_wdat));
        end
        if (v.nbits == 32) begin
            check({tag, "/miso_word"}, mw, {16'h0000, v.exp_rdata});
            check({tag, "/miso_tail"}, 32'(tail), 32'd0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [9];
        vec_t        v;
        logic [31:0] fr, f;
        logic        mi;
        int          n, d, hold;
        bit          acked;

        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = mem_init(i);
            model_mem[i] = mem_init(i);
        end

        //            frame         bits dly hold txn wr    addr   wdat     len rdata    to
        tbl[0] = '{32'h8002_000A, 32, 1,  0,  1, 1'b1, 8'h02, 16'h000A, 1,  16'h0000, 0};
        tbl[1] = '{32'h0000_1234, 32, 1,  0,  1, 1'b0, 8'h00, 16'h0000, 1,  16'h0142, 0};
        tbl[2] = '{32'h0005_0000, 32, 0,  20, 1, 1'b0, 8'h05, 16'h0000, 15, 16'hDEAD, 1};
        tbl[3] = '{32'h8004_0055, 20, 1,  0,  0, 1'b1, 8'h04, 16'h0055, 0,  16'h0000, 0};
        tbl[4] = '{32'h8004_BEEF, 32, 3,  0,  1, 1'b1, 8'h04, 16'hBEEF, 3,  16'h0000, 0};
        tbl[5] = '{32'h7F04_0000, 32, 2,  0,  1, 1'b0, 8'h04, 16'h0000, 2,  16'hBEEF, 0};
        tbl[6] = '{32'hFF10_5555, 32, 15, 0,  1, 1'b1, 8'h10, 16'h5555, 15, 16'h0000, 0};
        tbl[7] = '{32'h0010_0000, 32, 1,  0,  1, 1'b0, 8'h10, 16'h0000, 1,  16'h5555, 0};
        tbl[8] = '{32'h0002_0000, 32, 3,  0,  1, 1'b0, 8'h02, 16'h0000, 3,  16'h000A, 0};

        repeat (3) @(negedge clk);
        check_quiet("reset_held");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset_released");

        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // CS rises while a read waits on a 5-cycle-late ack.
        ack_delay = 5;
        txq.delete();
        to_pulses = 0;
        fr = 32'h0009_0000;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_rd/oe_on", 32'(spi_miso_oe), 32'd1);
        for (int i = 0; i < 16; i++) spi_bit(fr[31-i], 0, mi);
        n = 0;
        while (!reg_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_rd/strobe", 32'(reg_rd), 32'd1);
        spi_cs_n = 1'b1;
        wait_idle("abort_rd");
        check("abort_rd/ntxn", 32'(txq.size()), 32'd1);
        if (txq.size() != 0) begin
            check("abort_rd/wr", 32'(txq[0].wr), 32'd0);
            check("abort_rd/addr", 32'(txq[0].addr), 32'h09);
            check("abort_rd/len", 32'(txq[0].len), 32'd5);
        end
        check("abort_rd/tmo", 32'(to_pulses), 32'd0);
        check("abort_rd/oe_off", 32'(spi_miso_oe), 32'd0);
        v = '{32'h8006_1111, 32, 1, 0, 1, 1'b1, 8'h06, 16'h1111, 1, 16'h0000, 0};
        run_vec(v, "after_abort");

        // Asynchronous reset while a never-acked read strobe is high.
        ack_delay = 0;
        fr = 32'h0033_0000;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) spi_bit(fr[31-i], 0, mi);
        n = 0;
        while (!reg_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid/strobe", 32'(reg_rd), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_quiet("rst_mid");
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        v = '{32'h8003_000F, 32, 1, 0, 1, 1'b1, 8'h03, 16'h000F, 1, 16'h0000, 0};
        run_vec(v, "after_rst");

        // Random frames against the transaction-level model.
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = mem_init(i);
            model_mem[i] = mem_init(i);
        end
        for (int k = 0; k < 40; k++) begin
            f = $urandom;
            d = $urandom_range(0, 17);
            hold = (d >= 1 && d <= 3) ? 0 : 20;
            acked = (d >= 1 && d <= ACK_TIMEOUT);
            v.frame = f;
            v.nbits = 32;
            v.ack_delay = d;
            v.hold16 = hold;
            v.exp_txn = 1;
            v.exp_wr = f[31];
            v.exp_addr = f[23:16];
            v.exp_wdat = f[15:0];
            v.exp_len = acked ? d : ACK_TIMEOUT;
            v.exp_rdata = f[31] ? 16'h0000 : (acked ? model_mem[f[23:16]] : 16'hDEAD);
            v.exp_to = acked ? 0 : 1;
            if (f[31] && acked) model_mem[f[23:16]] = f[15:0];
            run_vec(v, $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
